fp_mult_issue_ctrl: RTL and testbench

- Issue/collect controller that sits directly upstream of the sequential single-precision multiplier core (fp_mult).
- Accepts operand pairs over a valid/ready handshake and classifies IEEE-754 special operands.
- Special operands are resolved locally, bypassing the core. All other pairs are launched on the core's start/ready interface; the product is captured and held until the consumer takes it.

---
 rtl/fp_mult_issue_ctrl.sv | 171 +++++++++++++++++
 tb/tb_fp_mult_issue_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mult_issue_ctrl.sv
// Issue/collect controller in front of the sequential single-precision multiplier core.
// Latency: 2 cycles for special-operand bypass, core latency + 3 cycles via the core.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, one op in flight.
//
// Ports:
//   clk, rst                   - clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready/in_a/b   - operand pair handshake
//   out_valid/out_ready        - result handshake; out_c product, out_flags {timeout, invalid, bypass}
//   mul_start/mul_a/mul_b      - launch pulse and held operands to the core
//   mul_c/mul_ready            - core result and done/idle indication
module fp_mult_issue_ctrl #(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_c,
   output logic [2:0]  out_flags,
   output logic        mul_start,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   input  logic [31:0] mul_c,
   input  logic        mul_ready
);

   localparam logic [31:0]      QNAN      = 32'h7FC0_0000;
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLASSIFY,
      S_LAUNCH,
      S_GUARD,
      S_WAIT,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [31:0]      mul_a_q, mul_a_d;
   logic [31:0]      mul_b_q, mul_b_d;
   logic [31:0]      out_c_q, out_c_d;
   logic [2:0]       out_flags_q, out_flags_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Operand classification works on the captured operands, so it is stable in CLASSIFY.
   logic a_exp_max, b_exp_max, a_frac_zero, b_frac_zero, a_exp_zero, b_exp_zero;
   logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   logic res_sign;

   assign a_exp_max   = (mul_a_q[30:23] == 8'hFF);
   assign b_exp_max   = (mul_b_q[30:23] == 8'hFF);
   assign a_exp_zero  = (mul_a_q[30:23] == 8'h00);
   assign b_exp_zero  = (mul_b_q[30:23] == 8'h00);
   assign a_frac_zero = (mul_a_q[22:0] == 23'd0);
   assign b_frac_zero = (mul_b_q[22:0] == 23'd0);

   assign a_nan  = a_exp_max & ~a_frac_zero;
   assign b_nan  = b_exp_max & ~b_frac_zero;
   assign a_inf  = a_exp_max & a_frac_zero;
   assign b_inf  = b_exp_max & b_frac_zero;
   assign a_zero = a_exp_zero & a_frac_zero;
   assign b_zero = b_exp_zero & b_frac_zero;

   assign res_sign = mul_a_q[31] ^ mul_b_q[31];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         mul_a_q     <= 32'd0;
         mul_b_q     <= 32'd0;
         out_c_q     <= 32'd0;
         out_flags_q <= 3'd0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         mul_a_q     <= mul_a_d;
         mul_b_q     <= mul_b_d;
         out_c_q     <= out_c_d;
         out_flags_q <= out_flags_d;
         cnt_q       <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      mul_a_d     = mul_a_q;
      mul_b_d     = mul_b_q;
      out_c_d     = out_c_q;
      out_flags_d = out_flags_q;
      cnt_d       = cnt_q;

      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               mul_a_d = in_a;
               mul_b_d = in_b;
               state_d = S_CLASSIFY;
            end
         end

         S_CLASSIFY: begin
            if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
               out_c_d     = QNAN;
               out_flags_d = 3'b011;
               state_d     = S_DONE;
            end else if (a_inf || b_inf) begin
               out_c_d     = {res_sign, 8'hFF, 23'd0};
               out_flags_d = 3'b001;
               state_d     = S_DONE;
            end else if (a_zero || b_zero) begin
               out_c_d     = {res_sign, 31'd0};
               out_flags_d = 3'b001;
               state_d     = S_DONE;
            end else begin
               state_d = S_LAUNCH;
            end
         end

         S_LAUNCH: begin
            cnt_d   = '0;
            state_d = S_GUARD;
         end

         // The core may still be showing ready from its previous operation here.
         S_GUARD: begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = S_WAIT;
         end

         // A core result in the same cycle as the timeout takes precedence.
         S_WAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (mul_ready) begin
               out_c_d     = mul_c;
               out_flags_d = 3'b000;
               state_d     = S_DONE;
            end else if (cnt_d >= TIMEOUT_C) begin
               out_c_d     = QNAN;
               out_flags_d = 3'b100;
               state_d     = S_DONE;
            end
         end

         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // in_ready is gated by rst so nothing is offered while reset is held.
   assign in_ready  = (state_q == S_IDLE) & ~rst;
   assign out_valid = (state_q == S_DONE);
   assign mul_start = (state_q == S_LAUNCH);
   assign out_c     = out_c_q;
   assign out_flags = out_flags_q;
   assign mul_a     = mul_a_q;
   assign mul_b     = mul_b_q;

endmodule

// File: tb/tb_fp_mult_issue_ctrl.sv
module tb_fp_mult_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_a = 32'd0;
   logic [31:0] in_b = 32'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_c;
   logic [2:0]  out_flags;
   logic        mul_start;
   logic [31:0] mul_a;
   logic [31:0] mul_b;
   logic [31:0] mul_c = 32'd0;
   logic        mul_ready = 1'b1;

   int n_checks = 0;
   int n_fail   = 0;

   fp_mult_issue_ctrl #(.TIMEOUT(64), .CNT_W(7)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_c     (out_c),
      .out_flags (out_flags),
      .mul_start (mul_start),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_c     (mul_c),
      .mul_ready (mul_ready)
   );

   always #5 clk = ~clk;

   // Core model. Mode 0: drops ready on start and raises it (with core_res) from the
   // 5th cycle after the start cycle. Mode 1: never finishes, but keeps a stale
   // ready high for the cycle after the start cycle.
   int          core_mode = 0;
   logic [31:0] core_res  = 32'd0;
   int          core_cnt  = 0;
   logic        core_dead = 1'b0;
   int          start_total = 0;

   always @(posedge clk) begin
      if (mul_start) begin
         start_total <= start_total + 1;
         if (core_mode == 0) begin
            mul_ready <= 1'b0;
            mul_c     <= 32'hDEAD_BEEF;
            core_cnt  <= 4;
         end else begin
            core_dead <= 1'b1;
         end
      end else if (core_dead) begin
         if (core_mode == 1) begin
            mul_ready <= 1'b0;
         end else begin
            core_dead <= 1'b0;
            mul_ready <= 1'b1;
         end
      end else if (core_cnt > 1) begin
         core_cnt <= core_cnt - 1;
      end else if (core_cnt == 1) begin
         core_cnt  <= 0;
         mul_ready <= 1'b1;
         mul_c     <= core_res;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Every task starts and ends 1 time unit after a rising edge.
   task automatic wait_in_ready();
      int g = 0;
      while (!in_ready && g < 200) begin
         @(posedge clk); #1; g++;
      end
      chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
   endtask

   // Hand over one pair; lat counts cycles from the handshake cycle to the first out_valid cycle.
   task automatic issue(input logic [31:0] a, input logic [31:0] b, output int lat);
      wait_in_ready();
      in_valid = 1'b1; in_a = a; in_b = b;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1; lat++;
      end
   endtask

   task automatic accept();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] core_res;
      logic [31:0] exp_c;
      logic [2:0]  exp_f;
      int          exp_lat;
      int          exp_starts;
   } vec_t;

   localparam int NV = 11;
   vec_t vecs [NV];

   initial begin
      int          lat, s0;
      logic [31:0] c0;
      logic [2:0]  f0;
      logic        stable, ir_low, seen_ready, ov_seen;

      vecs[0]  = '{32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 32'h40C0_0000, 3'b000, 8, 1};
      vecs[1]  = '{32'hFF80_0000, 32'h3F80_0000, 32'h0,         32'hFF80_0000, 3'b001, 2, 0};
      vecs[2]  = '{32'h7F80_0000, 32'h0000_0000, 32'h0,         32'h7FC0_0000, 3'b011, 2, 0};
      vecs[3]  = '{32'h7FC0_0001, 32'h3F80_0000, 32'h0,         32'h7FC0_0000, 3'b011, 2, 0};
      vecs[4]  = '{32'h8000_0000, 32'h4000_0000, 32'h0,         32'h8000_0000, 3'b001, 2, 0};
      vecs[5]  = '{32'hC000_0000, 32'h7F80_0000, 32'h0,         32'hFF80_0000, 3'b001, 2, 0};
      vecs[6]  = '{32'h0000_0000, 32'hFF80_0000, 32'h0,         32'h7FC0_0000, 3'b011, 2, 0};
      vecs[7]  = '{32'hBF80_0000, 32'h8000_0000, 32'h0,         32'h0000_0000, 3'b001, 2, 0};
      vecs[8]  = '{32'h3F80_0000, 32'hFFFF_FFFF, 32'h0,         32'h7FC0_0000, 3'b011, 2, 0};
      vecs[9]  = '{32'h0000_0001, 32'h3F80_0000, 32'h0000_0001, 32'h0000_0001, 3'b000, 8, 1};
      vecs[10] = '{32'hC040_0000, 32'h4000_0000, 32'hC0C0_0000, 32'hC0C0_0000, 3'b000, 8, 1};

      // Reset state
      @(posedge clk); @(posedge clk); #1;
      chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_c",     out_c,              32'd0);
      chk("rst_out_flags", {29'd0, out_flags}, 32'd0);
      chk("rst_mul_start", {31'd0, mul_start}, 32'd0);
      chk("rst_mul_a",     mul_a,              32'd0);
      chk("rst_mul_b",     mul_b,              32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;

      // Directed vector table
      for (int i = 0; i < NV; i++) begin
         core_res = vecs[i].core_res;
         s0 = start_total;
         issue(vecs[i].a, vecs[i].b, lat);
         chk($sformatf("v%0d_out_c", i),   out_c,              vecs[i].exp_c);
         chk($sformatf("v%0d_flags", i),   {29'd0, out_flags}, {29'd0, vecs[i].exp_f});
         chk($sformatf("v%0d_latency", i), lat,                vecs[i].exp_lat);
         chk($sformatf("v%0d_starts", i),  start_total - s0,   vecs[i].exp_starts);
         chk($sformatf("v%0d_mul_a", i),   mul_a,              vecs[i].a);
         chk($sformatf("v%0d_mul_b", i),   mul_b,              vecs[i].b);
         accept();
      end

      // Back-pressure: result held for 10 cycles
      issue(32'h8000_0000, 32'h4000_0000, lat);
      c0 = out_c; f0 = out_flags;
      chk("bp_c", c0, 32'h8000_0000);
      stable = 1'b1; ir_low = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (!out_valid || out_c !== c0 || out_flags !== f0) stable = 1'b0;
         if (in_ready) ir_low = 1'b0;
      end
      chk("bp_stable", {31'd0, stable}, 32'd1);
      chk("bp_in_ready_low", {31'd0, ir_low}, 32'd1);
      out_ready = 1'b1;
      #1;
      chk("bp_accept_cycle_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp_out_valid_drop", {31'd0, out_valid}, 32'd0);
      chk("bp_in_ready_back",  {31'd0, in_ready},  32'd1);

      // Timeout with a stale ready visible in GUARD
      core_mode = 1;
      s0 = start_total;
      issue(32'h4000_0000, 32'h4000_0000, lat);
      chk("to_out_c",   out_c,              32'h7FC0_0000);
      chk("to_flags",   {29'd0, out_flags}, 32'h4);
      chk("to_latency", lat,                67);
      chk("to_starts",  start_total - s0,   1);
      accept();
      core_mode = 0;
      @(posedge clk); #1;

      // Reset in the middle of WAIT
      core_res = 32'h4120_0000;
      wait_in_ready();
      in_valid = 1'b1; in_a = 32'h4000_0000; in_b = 32'h4040_0000;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("rw_launch", {31'd0, mul_start}, 32'd1);
      @(posedge clk); @(posedge clk); @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("rw_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rw_out_c",     out_c,              32'd0);
      chk("rw_flags",     {29'd0, out_flags}, 32'd0);
      chk("rw_mul_a",     mul_a,              32'd0);
      chk("rw_in_ready",  {31'd0, in_ready},  32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      ov_seen = 1'b0; seen_ready = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (out_valid) ov_seen = 1'b1;
         if (mul_ready) seen_ready = 1'b1;
      end
      chk("rw_late_ready_present", {31'd0, seen_ready}, 32'd1);
      chk("rw_no_spurious_valid",  {31'd0, ov_seen},    32'd0);

      core_res = 32'h4010_0000;
      s0 = start_total;
      issue(32'h3FC0_0000, 32'h3FC0_0000, lat);
      chk("rw_next_c",       out_c,              32'h4010_0000);
      chk("rw_next_flags",   {29'd0, out_flags}, 32'd0);
      chk("rw_next_latency", lat,                8);
      chk("rw_next_starts",  start_total - s0,   1);
      accept();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
